// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR box picker.
package lfsr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } pick_state_t;

  // All-zero is the LFSR lockup state, so a zero seed is replaced by this value.
  localparam int unsigned LOCKUP_SEED = 1;

endpackage

// File: rtl/lfsr_fib.sv
// Fibonacci LFSR: shift left, feedback = XOR of tapped bits into bit 0.
module lfsr_fib #(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] TAPS      = 32'h0000_00B8,
  parameter logic [31:0] RESET_VAL = 32'd1
) (
  input  logic             CLOCK_50,
  input  logic             reset_signal,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    next    = {state_q[WIDTH-2:0], ^(state_q & TAPS[WIDTH-1:0])};
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (en) begin
      state_d = next;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) begin
      state_q <= RESET_VAL[WIDTH-1:0];
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_box_picker.sv
// Random target selector: LFSR candidates mapped onto NUM_BOXES by rejection
// sampling, with optional no-repeat rule and bounded-retry fallback.
module lfsr_box_picker
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH            = 8,
  parameter logic [31:0] TAPS             = 32'h0000_00B8,
  parameter logic [31:0] SEED_DEFAULT     = 32'd1,
  parameter int unsigned NUM_BOXES        = 5,
  parameter int unsigned BOX_W            = 3,
  parameter int unsigned NO_REPEAT        = 1,
  parameter int unsigned MAX_TRIES        = 16,
  parameter int unsigned USE_COUNTER_SEED = 1,
  parameter int unsigned AUTO_PERIOD      = 0
) (
  input  logic             CLOCK_50,
  input  logic             reset_signal,
  input  logic             req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [BOX_W-1:0] box_out,
  output logic             box_valid,
  output logic             fallback,
  output logic             busy,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int unsigned TMR_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [BOX_W:0]   NUM_B    = (BOX_W + 1)'(NUM_BOXES);
  localparam logic [BOX_W-1:0] LAST_BOX = BOX_W'(NUM_BOXES - 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

  pick_state_t      state_q, state_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [BOX_W-1:0] box_q, box_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             fb_q, fb_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic             tick;
  logic             lfsr_en;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_raw;
  logic [WIDTH-1:0] seed_val;
  logic [BOX_W-1:0] cand;
  logic             accept;

  lfsr_fib #(
    .WIDTH    (WIDTH),
    .TAPS     (TAPS),
    .RESET_VAL(SEED_DEFAULT)
  ) u_lfsr (
    .CLOCK_50    (CLOCK_50),
    .reset_signal(reset_signal),
    .load        (seed_load),
    .load_val    (seed_val),
    .en          (lfsr_en),
    .state       (lfsr_state),
    .next        (lfsr_next)
  );

  always_comb begin
    cnt_d    = cnt_q + WIDTH'(1);
    tick     = (AUTO_PERIOD != 0) && (tmr_q == TMR_LAST);
    tmr_d    = '0;
    if ((AUTO_PERIOD != 0) && !tick) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
    seed_raw = (USE_COUNTER_SEED != 0) ? cnt_q : seed_in;
    seed_val = (seed_raw == '0) ? WIDTH'(LOCKUP_SEED) : seed_raw;
    cand     = lfsr_next[BOX_W-1:0];
    accept   = ({1'b0, cand} < NUM_B) &&
               !((NO_REPEAT != 0) && last_q && (cand == box_q));
  end

  always_comb begin
    state_d = state_q;
    try_d   = try_q;
    box_d   = box_q;
    last_d  = last_q;
    valid_d = 1'b0;
    fb_d    = 1'b0;
    lfsr_en = 1'b0;
    // seed_load pre-empts everything, including a same-cycle request.
    if (seed_load) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req || tick) begin
            state_d = ST_DRAW;
            try_d   = '0;
          end
        end
        ST_DRAW: begin
          lfsr_en = 1'b1;
          if (accept) begin
            box_d   = cand;
            last_d  = 1'b1;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else if (try_q == TRY_LAST) begin
            box_d   = last_q ? ((box_q == LAST_BOX) ? '0 : box_q + BOX_W'(1)) : '0;
            last_d  = 1'b1;
            valid_d = 1'b1;
            fb_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            try_d = try_q + TRY_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) begin
      state_q <= ST_IDLE;
      try_q   <= '0;
      box_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      fb_q    <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      try_q   <= try_d;
      box_q   <= box_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      fb_q    <= fb_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  assign box_out   = box_q;
  assign box_valid = valid_q;
  assign fallback  = fb_q;
  assign busy      = (state_q == ST_DRAW);

endmodule
